// File: rtl/fpro_bus_pkg.sv
// Shared FPro bus widths, the queued command record and the master FSM states.
package fpro_bus_pkg;

    localparam int FPRO_AW = 21;
    localparam int FPRO_DW = 32;
    localparam int SLOT_W  = 6;
    localparam int REG_W   = 5;

    typedef struct packed {
        logic               wr;
        logic [FPRO_AW-1:0] addr;
        logic [FPRO_DW-1:0] wr_data;
    } cmd_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        WAIT   = 2'd2,
        RESP   = 2'd3
    } state_t;

endpackage

// File: rtl/mmio_cmd_fifo.sv
// Synchronous command FIFO, depth 2**AW; pointers carry an extra wrap bit for full/empty.
module mmio_cmd_fifo
    import fpro_bus_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  cmd_t din,
    input  logic pop,
    output cmd_t dout,
    output logic full,
    output logic empty
);

    localparam int DEPTH = 1 << AW;

    logic [AW:0] wp_q;
    logic [AW:0] rp_q;
    cmd_t        mem_q [DEPTH];
    logic        push_ok;
    logic        pop_ok;

    assign empty   = (wp_q == rp_q);
    assign full    = (wp_q[AW] != rp_q[AW]) && (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem_q[rp_q[AW-1:0]];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (push_ok) wp_q <= wp_q + {{AW{1'b0}}, 1'b1};
            if (pop_ok)  rp_q <= rp_q + {{AW{1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wp_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/fpro_mmio_master.sv
// FPro MMIO initiator: one bus transaction and one response per queued command.
//   state  | meaning
//   IDLE   | bus idle, waiting for a queued command
//   STROBE | cs plus a one-cycle wr/rd strobe on the bus
//   WAIT   | cs/addr held for RD_LAT extra cycles before read data is sampled
//   RESP   | response presented until rsp_ready; may launch the next command
module fpro_mmio_master
    import fpro_bus_pkg::*;
#(
    parameter int FIFO_AW = 2,
    parameter int RD_LAT  = 0
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    input  logic               cmd_wr,
    input  logic [FPRO_AW-1:0] cmd_addr,
    input  logic [FPRO_DW-1:0] cmd_wr_data,
    output logic               rsp_valid,
    input  logic               rsp_ready,
    output logic               rsp_wr,
    output logic [FPRO_DW-1:0] rsp_rd_data,
    output logic               busy,
    output logic               mmio_cs,
    output logic               mmio_wr,
    output logic               mmio_rd,
    output logic [FPRO_AW-1:0] mmio_addr,
    output logic [FPRO_DW-1:0] mmio_wr_data,
    input  logic [FPRO_DW-1:0] mmio_rd_data
);

    localparam logic [2:0] LAT = 3'(RD_LAT);

    state_t             state_q, state_d;
    logic [2:0]         cnt_q, cnt_d;
    logic               cs_q, cs_d;
    logic               wr_q, wr_d;
    logic               rd_q, rd_d;
    logic [FPRO_AW-1:0] addr_q, addr_d;
    logic [FPRO_DW-1:0] wdata_q, wdata_d;
    logic               rv_q, rv_d;
    logic               rwr_q, rwr_d;
    logic [FPRO_DW-1:0] rdat_q, rdat_d;

    cmd_t fifo_din;
    cmd_t fifo_head;
    logic fifo_full;
    logic fifo_empty;
    logic fifo_pop;

    assign fifo_din = {cmd_wr, cmd_addr, cmd_wr_data};

    mmio_cmd_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_valid),
        .din   (fifo_din),
        .pop   (fifo_pop),
        .dout  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // A response handshake frees the FSM in the same edge that launches the next command.
    assign fifo_pop = !fifo_empty && ((state_q == IDLE) || ((state_q == RESP) && rsp_ready));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        cs_d    = cs_q;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rv_d    = rv_q;
        rwr_d   = rwr_q;
        rdat_d  = rdat_q;
        case (state_q)
            IDLE: ;
            STROBE: begin
                if (wr_q || (LAT == 3'd0)) begin
                    cs_d    = 1'b0;
                    rv_d    = 1'b1;
                    rdat_d  = wr_q ? '0 : mmio_rd_data;
                    state_d = RESP;
                end else begin
                    cnt_d   = LAT;
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (cnt_q == 3'd1) begin
                    cs_d    = 1'b0;
                    rv_d    = 1'b1;
                    rdat_d  = mmio_rd_data;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    rv_d    = 1'b0;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        if (fifo_pop) begin
            state_d = STROBE;
            cs_d    = 1'b1;
            wr_d    = fifo_head.wr;
            rd_d    = !fifo_head.wr;
            addr_d  = fifo_head.addr;
            wdata_d = fifo_head.wr_data;
            rwr_d   = fifo_head.wr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b0;
            wr_q    <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rv_q    <= 1'b0;
            rwr_q   <= 1'b0;
            rdat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rv_q    <= rv_d;
            rwr_q   <= rwr_d;
            rdat_q  <= rdat_d;
        end
    end

    assign cmd_ready    = !fifo_full;
    assign busy         = !fifo_empty || (state_q != IDLE);
    assign mmio_cs      = cs_q;
    assign mmio_wr      = wr_q;
    assign mmio_rd      = rd_q;
    assign mmio_addr    = addr_q;
    assign mmio_wr_data = wdata_q;
    assign rsp_valid    = rv_q;
    assign rsp_wr       = rwr_q;
    assign rsp_rd_data  = rdat_q;

endmodule

// File: tb/tb_fpro_mmio_master.sv
// Bench for fpro_mmio_master: three instances (RD_LAT 0/2/3) each checked against a queue model.
module tb_fpro_mmio_master;

    typedef struct {
        bit        wr;
        bit [20:0] addr;
        bit [31:0] data;
    } tcmd_t;

    logic       clk = 1'b0;
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [2:0] done = 3'b000;

    always #5 clk = ~clk;

    // Slot register file: read value is a fixed function of the word address.
    function automatic logic [31:0] slot_val(input logic [20:0] a);
        return {11'h0, a} ^ 32'h0000_0093;
    endfunction

    task automatic chk(input int lat, input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL lat%0d %s: got %h expected %h", lat, nm, act, exp);
        end
    endtask

    for (genvar g = 0; g < 3; g++) begin : g_lat
        localparam int L = (g == 0) ? 0 : ((g == 1) ? 2 : 3);

        logic        rst;
        logic        cmd_valid, cmd_ready, cmd_wr;
        logic [20:0] cmd_addr;
        logic [31:0] cmd_wr_data;
        logic        rsp_valid, rsp_ready, rsp_wr;
        logic [31:0] rsp_rd_data;
        logic        busy, mmio_cs, mmio_wr, mmio_rd;
        logic [20:0] mmio_addr;
        logic [31:0] mmio_wr_data, mmio_rd_data;
        int          cs_run;
        int          n_hs = 0;

        fpro_mmio_master #(.FIFO_AW(2), .RD_LAT(L)) dut (
            .clk          (clk),
            .reset        (rst),
            .cmd_valid    (cmd_valid),
            .cmd_ready    (cmd_ready),
            .cmd_wr       (cmd_wr),
            .cmd_addr     (cmd_addr),
            .cmd_wr_data  (cmd_wr_data),
            .rsp_valid    (rsp_valid),
            .rsp_ready    (rsp_ready),
            .rsp_wr       (rsp_wr),
            .rsp_rd_data  (rsp_rd_data),
            .busy         (busy),
            .mmio_cs      (mmio_cs),
            .mmio_wr      (mmio_wr),
            .mmio_rd      (mmio_rd),
            .mmio_addr    (mmio_addr),
            .mmio_wr_data (mmio_wr_data),
            .mmio_rd_data (mmio_rd_data)
        );

        // Data is only correct in the L-th cycle of chip select; anything else returns junk.
        always @(posedge clk or posedge rst) begin
            if (rst) cs_run <= 0;
            else     cs_run <= mmio_cs ? cs_run + 1 : 0;
        end
        assign mmio_rd_data = (mmio_cs && cs_run == L) ? slot_val(mmio_addr) : (32'hBAD0_0000 | 32'(cs_run));

        tcmd_t     mq[$];
        tcmd_t     m_cur;
        bit        m_act = 0;
        int        m_age = 0;
        bit        m_rv = 0;
        bit        m_rwr = 0;
        bit [31:0] m_rdat = 0;
        bit [20:0] m_addr = 0;
        bit [31:0] m_wd = 0;

        initial forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mq.delete();
                m_act = 0; m_age = 0; m_rv = 0; m_rwr = 0; m_rdat = 0; m_addr = 0; m_wd = 0;
            end else begin : upd
                bit    full0, rv0, act0, hs;
                tcmd_t nc;
                full0 = (mq.size() == 4);
                rv0   = m_rv;
                act0  = m_act;
                hs    = m_rv && rsp_ready;
                if (hs) begin
                    m_rv = 0;
                    n_hs++;
                end
                if (act0) begin
                    if (m_age == (m_cur.wr ? 0 : L)) begin
                        m_act  = 0;
                        m_rv   = 1;
                        m_rwr  = m_cur.wr;
                        m_rdat = m_cur.wr ? 32'h0 : slot_val(m_cur.addr);
                    end else begin
                        m_age++;
                    end
                end else if ((!rv0 || hs) && mq.size() > 0) begin
                    m_cur  = mq.pop_front();
                    m_act  = 1;
                    m_age  = 0;
                    m_addr = m_cur.addr;
                    m_wd   = m_cur.data;
                end
                if (cmd_valid && !full0) begin
                    nc.wr = cmd_wr; nc.addr = cmd_addr; nc.data = cmd_wr_data;
                    mq.push_back(nc);
                end
            end
        end

        initial forever begin
            @(negedge clk);
            if (rst === 1'b0) begin
                chk(L, "cmd_ready", cmd_ready, mq.size() < 4);
                chk(L, "busy", busy, (mq.size() > 0) || m_act || m_rv);
                chk(L, "mmio_cs", mmio_cs, m_act);
                chk(L, "mmio_wr", mmio_wr, m_act && m_age == 0 && m_cur.wr);
                chk(L, "mmio_rd", mmio_rd, m_act && m_age == 0 && !m_cur.wr);
                chk(L, "mmio_addr", mmio_addr, m_addr);
                chk(L, "mmio_wr_data", mmio_wr_data, m_wd);
                chk(L, "rsp_valid", rsp_valid, m_rv);
                if (m_rv) begin
                    chk(L, "rsp_wr", rsp_wr, m_rwr);
                    chk(L, "rsp_rd_data", rsp_rd_data, m_rdat);
                end
            end
        end

        task automatic put(input logic w, input logic [20:0] a, input logic [31:0] d);
            cmd_valid = 1'b1; cmd_wr = w; cmd_addr = a; cmd_wr_data = d;
        endtask

        task automatic wait_acc();
            int t = 0;
            while (!cmd_ready && t < 300) begin
                @(posedge clk); #1;
                t++;
            end
            chk(L, "accept_within_bound", cmd_ready, 1);
            @(posedge clk); #1;
            cmd_valid = 1'b0;
        endtask

        task automatic wait_idle();
            int t = 0;
            while (busy && t < 500) begin
                @(posedge clk); #1;
                t++;
            end
            chk(L, "idle_within_bound", busy, 0);
        endtask

        initial begin
            int hs0;
            rst = 1'b1; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = '0; cmd_wr_data = '0; rsp_ready = 1'b0;
            repeat (3) @(posedge clk);
            #1 rst = 1'b0;
            chk(L, "reset_cmd_ready", cmd_ready, 1);
            chk(L, "reset_busy", busy, 0);
            chk(L, "reset_cs", mmio_cs, 0);
            chk(L, "reset_rsp_valid", rsp_valid, 0);

            // Reset while a read is in flight (mid-WAIT for the longer latencies).
            rsp_ready = 1'b1;
            put(1'b0, 21'h00060, 32'h0);
            wait_acc();
            @(posedge clk); #1;
            @(posedge clk); #1;
            chk(L, "pre_reset_cs", mmio_cs, L > 0);
            #2 rst = 1'b1;
            #1;
            chk(L, "arst_cs", mmio_cs, 0);
            chk(L, "arst_wr_rd", {mmio_wr, mmio_rd}, 0);
            chk(L, "arst_addr", mmio_addr, 0);
            chk(L, "arst_wdata", mmio_wr_data, 0);
            chk(L, "arst_rsp_valid", rsp_valid, 0);
            chk(L, "arst_cmd_ready", cmd_ready, 1);
            chk(L, "arst_busy", busy, 0);
            @(posedge clk); #1 rst = 1'b0;

            // Single write: strobe one cycle after the accept edge, response the cycle after.
            put(1'b1, 21'h00040, 32'hA5A5_0001);
            wait_acc();
            @(posedge clk); #1;
            chk(L, "wr_cs", mmio_cs, 1);
            chk(L, "wr_strobe", {mmio_wr, mmio_rd}, 2'b10);
            chk(L, "wr_addr", mmio_addr, 21'h00040);
            chk(L, "wr_data", mmio_wr_data, 32'hA5A5_0001);
            @(posedge clk); #1;
            chk(L, "wr_rsp_valid", rsp_valid, 1);
            chk(L, "wr_rsp_wr", rsp_wr, 1);
            chk(L, "wr_rsp_data", rsp_rd_data, 0);
            wait_idle();

            // Single read: cs held L+1 cycles, rd only in the first, data 0xF3.
            put(1'b0, 21'h00060, 32'h0);
            wait_acc();
            for (int k = 0; k <= L; k++) begin
                @(posedge clk); #1;
                chk(L, "rd_cs_held", mmio_cs, 1);
                chk(L, "rd_strobe", mmio_rd, k == 0);
            end
            @(posedge clk); #1;
            chk(L, "rd_rsp_valid", rsp_valid, 1);
            chk(L, "rd_rsp_wr", rsp_wr, 0);
            chk(L, "rd_rsp_data", rsp_rd_data, 32'h0000_00F3);
            wait_idle();

            // Back-pressure: with responses stalled, the FIFO fills and refuses a further command.
            rsp_ready = 1'b0;
            for (int i = 0; i < 5; i++) begin
                put(1'b0, 21'h00100 | 21'(i), 32'h0);
                wait_acc();
            end
            chk(L, "fifo_full_ready", cmd_ready, 0);
            put(1'b1, 21'h001FF, 32'hCAFE_0006);
            repeat (5) begin
                @(posedge clk); #1;
            end
            chk(L, "full_still_refused", cmd_ready, 0);
            chk(L, "full_first_rsp", rsp_valid, 1);
            rsp_ready = 1'b1;
            wait_acc();
            wait_idle();

            // Streaming alternating writes and reads.
            hs0 = n_hs;
            for (int i = 0; i < 8; i++) begin
                put(i % 2 == 0, 21'h00200 + 21'(i * 33), 32'h1000_0000 + 32'(i));
                wait_acc();
            end
            wait_idle();
            chk(L, "stream_responses", n_hs - hs0, 8);

            // Random response back-pressure.
            fork
                begin
                    for (int i = 0; i < 12; i++) begin
                        put($urandom_range(0, 1) == 1, 21'($urandom_range(0, 2047)), $urandom);
                        wait_acc();
                    end
                end
                begin
                    for (int c = 0; c < 300; c++) begin
                        @(posedge clk); #1;
                        rsp_ready = ($urandom_range(0, 1) == 1);
                    end
                end
            join
            rsp_ready = 1'b1;
            wait_idle();
            done[g] = 1'b1;
        end
    end

    initial begin
        for (int c = 0; c < 60000 && done != 3'b111; c++) @(posedge clk);
        chk(-1, "all_instances_done", {29'h0, done}, 32'h7);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
